// File: rtl/edge_event_monitor.sv
// ---------------------------------------------------------------------------
// edge_event_monitor
//
// Purpose:
//   Watches CHANNELS asynchronous level signals. Each one passes through a
//   synchroniser. Rising, falling or both edges are detected per channel,
//   as selected by mode. Each channel keeps a saturating count of its
//   qualified edges. Events are handed out one at a time through a
//   valid/ready slot, chosen by a round-robin arbiter.
//
// Ports:
//   clk        in   1                     clock, rising edge
//   rst_n      in   1                     asynchronous reset, active low
//   sig_in     in   CHANNELS              monitored signals (async to clk)
//   mode       in   2*CHANNELS            per channel: 00 off, 01 rise,
//                                         10 fall, 11 both
//   clr        in   1                     zero counters and overflow flags
//   edge_pulse out  CHANNELS              one-cycle pulse per qualified edge
//   edge_cnt   out  CHANNELS*CNT_WIDTH    saturating counters, channel c
//                                         at [c*CNT_WIDTH +: CNT_WIDTH]
//   overflow   out  CHANNELS              sticky: an edge arrived while that
//                                         channel already had a pending event
//   evt_valid  out  1                     event slot occupied
//   evt_chan   out  CHAN_W                channel of the event in the slot
//   evt_ready  in   1                     consumer accepts the slot event
// ---------------------------------------------------------------------------
module edge_event_monitor #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           sig_in,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic                          clr,
  output logic [CHANNELS-1:0]           edge_pulse,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_cnt,
  output logic [CHANNELS-1:0]           overflow,
  output logic                          evt_valid,
  output logic [CHAN_W-1:0]             evt_chan,
  input  logic                          evt_ready
);

  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0]  sync_q, sync_d;
  logic [CHANNELS-1:0]                   prev_q, prev_d;
  logic [WARM_W-1:0]                     warm_q, warm_d;
  logic [CHANNELS-1:0]                   edge_pulse_q, edge_pulse_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0]                   overflow_q, overflow_d;
  logic [CHANNELS-1:0]                   pending_q, pending_d;
  logic                                  evt_valid_q, evt_valid_d;
  logic [CHAN_W-1:0]                     evt_chan_q, evt_chan_d;
  logic [CHAN_W-1:0]                     ptr_q, ptr_d;

  logic [CHANNELS-1:0] sync_s;
  logic                detect_en;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] ovf_cond;
  logic                slot_load;
  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic [CHAN_W-1:0]   grant_chan;
  logic [CHAN_W-1:0]   idx;

  // Channel number `offset` positions after `base`, wrapping at CHANNELS.
  function automatic logic [CHAN_W-1:0] rr_index(input logic [CHAN_W-1:0] base,
                                                 input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return CHAN_W'(sum);
  endfunction

  // Synchroniser shift chain, previous-sample flop and warm-up counter.
  // Edge detection stays off until the chain has filled with real samples.
  // This stops a signal that is already high at reset release from
  // looking like a rising edge.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_s    = sync_q[SYNC_STAGES-1];
    prev_d    = sync_s;
    detect_en = (warm_q == WARM_W'(WARM_CYCLES));
    warm_d    = detect_en ? warm_q : warm_q + 1'b1;
  end

  // Edge qualification against the per-channel mode bits.
  always_comb begin
    qual = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      qual[c] = detect_en &
                ((mode[2*c]   &  sync_s[c] & ~prev_q[c]) |
                 (mode[2*c+1] & ~sync_s[c] &  prev_q[c]));
    end
    edge_pulse_d = qual;
  end

  // Round-robin arbiter. The search starts at ptr_q, which always points
  // one past the most recently granted channel.
  always_comb begin
    slot_load  = !evt_valid_q || evt_ready;
    grant      = '0;
    grant_any  = 1'b0;
    grant_chan = '0;
    idx        = '0;
    if (slot_load) begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = rr_index(ptr_q, k);
        if (!grant_any && pending_q[idx]) begin
          grant_any  = 1'b1;
          grant_chan = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  // Counters, pending bits, overflow flags and the output slot.
  // A new edge on the channel being granted re-sets its pending bit.
  // That edge is a fresh event, not an overflow.
  always_comb begin
    ovf_cond  = qual & pending_q & ~grant;
    pending_d = (pending_q & ~grant) | qual;
    overflow_d = clr ? ovf_cond : (overflow_q | ovf_cond);
    for (int c = 0; c < CHANNELS; c++) begin
      if (clr) begin
        cnt_d[c] = CNT_WIDTH'(qual[c]);
      end else if (qual[c] && (cnt_q[c] != '1)) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c];
      end
    end
    evt_valid_d = slot_load ? grant_any : evt_valid_q;
    evt_chan_d  = (slot_load && grant_any) ? grant_chan : evt_chan_q;
    ptr_d       = grant_any ? rr_index(grant_chan, 1) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      prev_q       <= '0;
      warm_q       <= '0;
      edge_pulse_q <= '0;
      cnt_q        <= '0;
      overflow_q   <= '0;
      pending_q    <= '0;
      evt_valid_q  <= 1'b0;
      evt_chan_q   <= '0;
      ptr_q        <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      warm_q       <= warm_d;
      edge_pulse_q <= edge_pulse_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      pending_q    <= pending_d;
      evt_valid_q  <= evt_valid_d;
      evt_chan_q   <= evt_chan_d;
      ptr_q        <= ptr_d;
    end
  end

  assign edge_pulse = edge_pulse_q;
  assign edge_cnt   = cnt_q;
  assign overflow   = overflow_q;
  assign evt_valid  = evt_valid_q;
  assign evt_chan   = evt_chan_q;

endmodule

// File: tb/tb_edge_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_edge_event_monitor
//
// Directed bench for edge_event_monitor (4 channels, 8-bit counters,
// 2-stage synchroniser). Expected event channels are queued whenever
// stimulus creates an event. A negedge monitor pops the queue on each
// valid/ready handshake and compares the channel.
// ---------------------------------------------------------------------------
module tb_edge_event_monitor;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sig_in;
  logic [7:0]  mode;
  logic        clr;
  logic [3:0]  edge_pulse;
  logic [31:0] edge_cnt;
  logic [3:0]  overflow;
  logic        evt_valid;
  logic [1:0]  evt_chan;
  logic        evt_ready;

  int nCompared;
  int nMismatched;
  int expQ[$];
  int expFallCnt;

  edge_event_monitor #(
    .CHANNELS(4),
    .CNT_WIDTH(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .mode(mode),
    .clr(clr),
    .edge_pulse(edge_pulse),
    .edge_cnt(edge_cnt),
    .overflow(overflow),
    .evt_valid(evt_valid),
    .evt_chan(evt_chan),
    .evt_ready(evt_ready)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts it and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then step 1 ns past the edge for drive/sample
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [7:0] m);
    sig_in = s;
    mode   = m;
  endtask

  // Scoreboard monitor: each handshake must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("evt_unexpected", {30'b0, evt_chan}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("evt_chan_order", {30'b0, evt_chan}, 32'(expQ.pop_front()));
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expFallCnt  = 0;
    rst_n       = 1'b0;
    clr         = 1'b0;
    evt_ready   = 1'b0;
    applyStimulus(4'b1111, 8'hFF);

    // 1: signals high at reset release, all channels in both-edge mode
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("warmup_pulse", {28'b0, edge_pulse}, 32'h0);
      checkOutput("warmup_valid", {31'b0, evt_valid}, 32'h0);
    end
    checkOutput("warmup_cnt", edge_cnt, 32'h0);
    checkOutput("warmup_ovf", {28'b0, overflow}, 32'h0);

    // Channels off: dropping every signal must be ignored
    applyStimulus(4'b0000, 8'h00);
    tick(6);
    checkOutput("mode_off_cnt", edge_cnt, 32'h0);
    checkOutput("mode_off_valid", {31'b0, evt_valid}, 32'h0);

    // 2: ch0 rising edge, sampled at the next clock (T)
    mode = 8'b0000_0001;
    tick(1);
    sig_in[0] = 1'b1;
    expQ.push_back(0);
    tick(3);
    checkOutput("t2_pulse_T+2", {28'b0, edge_pulse}, 32'h1);
    checkOutput("t2_cnt0", {24'b0, edge_cnt[7:0]}, 32'd1);
    checkOutput("t2_valid_T+2", {31'b0, evt_valid}, 32'h0);
    tick(1);
    checkOutput("t2_valid_T+3", {31'b0, evt_valid}, 32'h1);
    checkOutput("t2_chan_T+3", {30'b0, evt_chan}, 32'h0);
    checkOutput("t2_pulse_T+3", {28'b0, edge_pulse}, 32'h0);
    evt_ready = 1'b1;
    tick(2);
    checkOutput("t2_valid_drained", {31'b0, evt_valid}, 32'h0);

    // 3: ch1 falling-edge mode, 300 falls, counter saturates
    mode = 8'b0000_1001;
    for (int i = 0; i < 300; i++) begin
      sig_in[1] = 1'b1;
      tick(2);
      sig_in[1] = 1'b0;
      expQ.push_back(1);
      expFallCnt++;
      tick(2);
    end
    tick(6);
    checkOutput("t3_cnt1_sat", {24'b0, edge_cnt[15:8]},
                (expFallCnt > 255) ? 32'd255 : 32'(expFallCnt));
    checkOutput("t3_no_ovf", {28'b0, overflow}, 32'h0);
    checkOutput("t3_queue_drained", 32'(expQ.size()), 32'h0);

    // 4: slot held by ch0, then two ch2 rises -> overflow on ch2
    evt_ready = 1'b0;
    mode      = 8'b0001_1001;
    sig_in[0] = 1'b0;
    tick(3);
    sig_in[0] = 1'b1;
    expQ.push_back(0);
    tick(5);
    checkOutput("t4_slot_valid", {31'b0, evt_valid}, 32'h1);
    checkOutput("t4_slot_chan", {30'b0, evt_chan}, 32'h0);
    sig_in[2] = 1'b1;
    expQ.push_back(2);
    tick(3);
    sig_in[2] = 1'b0;
    tick(3);
    sig_in[2] = 1'b1;
    tick(5);
    checkOutput("t4_ovf", {28'b0, overflow}, 32'b0100);
    checkOutput("t4_cnt_all", edge_cnt, 32'h0002_FF02);
    checkOutput("t4_chan_held", {30'b0, evt_chan}, 32'h0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checkOutput("t4_clr_cnt", edge_cnt, 32'h0);
    checkOutput("t4_clr_ovf", {28'b0, overflow}, 32'h0);
    checkOutput("t4_clr_valid_kept", {31'b0, evt_valid}, 32'h1);
    checkOutput("t4_clr_chan_kept", {30'b0, evt_chan}, 32'h0);

    // 6: reset with slot full and ch2 pending -> outputs clear at once
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_pulse", {28'b0, edge_pulse}, 32'h0);
    checkOutput("t6_rst_cnt", edge_cnt, 32'h0);
    checkOutput("t6_rst_ovf", {28'b0, overflow}, 32'h0);
    checkOutput("t6_rst_valid", {31'b0, evt_valid}, 32'h0);
    checkOutput("t6_rst_chan", {30'b0, evt_chan}, 32'h0);
    expQ.delete();
    applyStimulus(4'b1111, 8'hFF);
    evt_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput("t6_warmup_pulse", {28'b0, edge_pulse}, 32'h0);
      checkOutput("t6_warmup_valid", {31'b0, evt_valid}, 32'h0);
    end

    // 5: simultaneous rises on all channels -> round-robin 0,1,2,3
    applyStimulus(4'b0000, 8'h55);
    tick(4);
    checkOutput("t5_falls_ignored", edge_cnt, 32'h0);
    expQ.push_back(0);
    expQ.push_back(1);
    expQ.push_back(2);
    expQ.push_back(3);
    sig_in = 4'b1111;
    tick(3);
    checkOutput("t5_pulse_all", {28'b0, edge_pulse}, 32'hF);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_rr_valid", {31'b0, evt_valid}, 32'h1);
      checkOutput("t5_rr_chan", {30'b0, evt_chan}, 32'(i));
      tick(1);
    end
    checkOutput("t5_rr_done", {31'b0, evt_valid}, 32'h0);

    // ch0 and ch3 together after ch3 was last granted -> ch0 first
    sig_in = 4'b0110;
    tick(4);
    expQ.push_back(0);
    expQ.push_back(3);
    sig_in = 4'b1111;
    tick(4);
    checkOutput("t5_wrap_first", {30'b0, evt_chan}, 32'h0);
    tick(1);
    checkOutput("t5_wrap_second", {30'b0, evt_chan}, 32'h3);
    tick(1);
    checkOutput("t5_wrap_done", {31'b0, evt_valid}, 32'h0);
    checkOutput("t5_cnt_all", edge_cnt, 32'h0201_0102);

    tick(3);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
